// File: rtl/if_stage_prefetch_pkg.sv
// Shared types for the instruction-fetch stage: fetch FSM states and the
// prefetch FIFO entry layout.
package if_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_stage_prefetch_fifo.sv
// Small power-of-two prefetch FIFO with synchronous flush; read data is
// presented combinationally from the head entry.
module prefetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  T                         din,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage: one-outstanding request FSM to instruction memory,
// prefetch FIFO, and a registered {pc+4, instruction, valid} toward decode.
module if_stage_prefetch
    import if_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        valid
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    logic          r_drop;
    logic          r_imem_req;
    logic [31:0]   r_imem_addr;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic          r_valid;

    fetch_entry_t  w_din;
    fetch_entry_t  w_dout;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    // After an ack fetch_pc already points one word past the request, so it is the entry's pc+4.
    assign w_push           = (r_state == WAIT) && imem_rvalid && !r_drop && !branch_taken;
    assign w_pop            = !branch_taken && !freeze && !w_empty;
    assign w_din.pc_plus4   = r_fetch_pc;
    assign w_din.instr      = imem_rdata;

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .flush (branch_taken),
        .din   (w_din),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop      <= 1'b0;
            r_imem_req  <= 1'b0;
            r_imem_addr <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (branch_taken) begin
                        r_fetch_pc  <= branch_address;
                        r_imem_addr <= branch_address;
                        r_imem_req  <= 1'b1;
                        r_state     <= REQ;
                    end else if (w_count < CW'(DEPTH)) begin
                        r_imem_addr <= r_fetch_pc;
                        r_imem_req  <= 1'b1;
                        r_state     <= REQ;
                    end
                end
                REQ: begin
                    // A redirect while the request is pending keeps fetch_pc on the target.
                    if (branch_taken) begin
                        r_fetch_pc <= branch_address;
                        r_drop     <= 1'b1;
                    end else if (imem_ack && !r_drop) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                    if (imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_drop  <= 1'b0;
                        r_state <= IDLE;
                        if (branch_taken) r_fetch_pc <= branch_address;
                    end else if (branch_taken) begin
                        r_fetch_pc <= branch_address;
                        r_drop     <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (branch_taken) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!freeze) begin
            if (!w_empty) begin
                r_valid <= 1'b1;
                r_pc    <= w_dout.pc_plus4;
                r_instr <= w_dout.instr;
            end else begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full && !w_pop));

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_imem_addr;
    assign pc          = r_pc;
    assign instruction = r_instr;
    assign valid       = r_valid;

endmodule
